approx_adder_error_monitor32: RTL

Streaming error-evaluation sink for the approximate adder family. It accepts {operand A, operand B, approximate sum} beats over a valid/ready handshake and recomputes the exact sum internally. Over a programmable batch it accumulates the standard error metrics: sample count, error count, maximum error distance, summed error distance and last error distance. It sits on the consumer side of an approximate adder under characterisation and replaces manual `$monitor` inspection with hardware-collected statistics.

---
 rtl/approx_adder_error_monitor32.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/approx_adder_error_monitor32.sv
// Streaming error-statistics sink for approximate adders: recomputes the exact sum
// of each accepted {A, B, approx} beat and accumulates error-distance metrics per batch.
module approx_adder_error_monitor32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] batch_len_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   approx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [WIDTH:0]   max_ed_o,
    output logic [ACC_W-1:0] sum_ed_o,
    output logic [WIDTH:0]   last_ed_o,
    output logic             sat_o
);

    localparam int SUM_W = WIDTH + 1;
    localparam int AW1   = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic               ready_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   acc_cnt;
    logic [CNT_W-1:0]   acc_next;
    logic               accept;

    logic               vld_p1;
    logic [WIDTH-1:0]   add1_p1;
    logic [WIDTH-1:0]   add2_p1;
    logic [SUM_W-1:0]   approx_p1;
    logic               vld_p2;
    logic [SUM_W-1:0]   ed_p2;
    logic [AW1-1:0]     sum_next;

    function automatic logic [SUM_W-1:0] abs_err(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [SUM_W-1:0] approx);
        logic [SUM_W-1:0] exact;
        exact = {1'b0, a} + {1'b0, b};
        return (exact >= approx) ? (exact - approx) : (approx - exact);
    endfunction

    // Returns the clamped sum in the low ACC_W bits and the clamp flag in the MSB.
    function automatic logic [AW1-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [SUM_W-1:0] ed);
        logic [AW1-1:0] s;
        s = {1'b0, acc} + AW1'(ed);
        if (s[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return s;
    endfunction

    assign accept   = valid_i && ready_q;
    assign acc_next = acc_cnt + 1'b1;
    assign sum_next = sat_add(sum_ed_o, ed_p2);
    assign ready_o  = ready_q;
    assign busy_o   = (state == RUN) || (state == DRAIN);
    assign done_o   = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            len_q        <= '0;
            acc_cnt      <= '0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            sample_cnt_o <= '0;
            err_cnt_o    <= '0;
            max_ed_o     <= '0;
            sum_ed_o     <= '0;
            last_ed_o    <= '0;
            sat_o        <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;

            if (vld_p2) begin
                sample_cnt_o <= sample_cnt_o + 1'b1;
                err_cnt_o    <= err_cnt_o + CNT_W'(ed_p2 != '0);
                if (ed_p2 > max_ed_o)
                    max_ed_o <= ed_p2;
                last_ed_o    <= ed_p2;
                sum_ed_o     <= sum_next[ACC_W-1:0];
                if (sum_next[ACC_W])
                    sat_o <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start_i && (batch_len_i != '0)) begin
                        state        <= RUN;
                        ready_q      <= 1'b1;
                        len_q        <= batch_len_i;
                        acc_cnt      <= '0;
                        sample_cnt_o <= '0;
                        err_cnt_o    <= '0;
                        max_ed_o     <= '0;
                        sum_ed_o     <= '0;
                        last_ed_o    <= '0;
                        sat_o        <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_next;
                        if (acc_next == len_q) begin
                            ready_q <= 1'b0;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!vld_p1 && !vld_p2)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage boundary p1 -> p2: operand capture, then error distance.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            add1_p1   <= add1_i;
            add2_p1   <= add2_i;
            approx_p1 <= approx_i;
        end
        if (vld_p1)
            ed_p2 <= abs_err(add1_p1, add2_p1, approx_p1);
    end

endmodule
